memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Two-port arbiter and sequencer in front of the A09 synchronous-read `Memory` block (16-bit data, 8-bit address, active-low `Write_EN`, one-cycle read latency). It shares the single memory between the instruction-fetch port (read-only) and the data load/store port (read/write). Round-robin arbitration resolves conflicts. The block drives `Memory`'s `Address`/`DIn`/`Write_EN` from registers and captures `DOut` back to the winning requester with a valid pulse.

## Interface
- `Data_WIDTH`, 16, memory data width
- `Address_WIDTH`, 8, memory address width

- `Clk`  in  1  system clock; all state changes on rising edge
- `Reset`  in  1  synchronous, active-high reset
- `Fetch_Req`  in  1  fetch read request; held with `Fetch_Addr` until `Fetch_Ack`
- `Fetch_Addr`  in  Address_WIDTH  fetch address
- `Fetch_Ack`  out  1  one-cycle pulse: fetch request accepted
- `Fetch_Data`  out  Data_WIDTH  fetched word; holds until next fetch completes
- `Fetch_Valid`  out  1  one-cycle pulse: `Fetch_Data` updated
- `Data_Req`  in  1  data request; held with `Data_We`/`Data_Addr`/`Data_WData` until `Data_Ack`
- `Data_We`  in  1  1 = write, 0 = read
- `Data_Addr`  in  Address_WIDTH  data address
- `Data_WData`  in  Data_WIDTH  write data
- `Data_Ack`  out  1  one-cycle pulse: data request accepted
- `Data_RData`  out  Data_WIDTH  read word; unchanged by writes
- `Data_Valid`  out  1  one-cycle pulse: read data ready or write committed
- `Mem_Address`  out  Address_WIDTH  to `Memory.Address`
- `Mem_DIn`  out  Data_WIDTH  to `Memory.DIn`
- `Mem_Write_EN`  out  1  to `Memory.Write_EN`, active low
- `Mem_DOut`  in  Data_WIDTH  from `Memory.DOut`

## Operation
- FSM states and transitions:
  - IDLE → ACCESS when any request is present.
  - ACCESS → CAPTURE unconditionally.
  - CAPTURE → IDLE unconditionally.
- Requests are sampled only in IDLE. The block is ignored while in ACCESS or CAPTURE.
- Grant rules in IDLE:
  - If only one port requests, that port is granted.
  - If both request, the port not granted most recently wins.
  - `last_grant` resets to fetch, so the first tie after reset goes to the data port.
  - `last_grant` updates on every grant.
- On the grant edge (IDLE→ACCESS), the following are registered:
  - `Mem_Address` ← granted address.
  - `Mem_DIn` ← `Data_WData` for a data write; otherwise unchanged.
  - `Mem_Write_EN` ← 0 only for a data write; otherwise 1.
  - The granted port's Ack is set to 1.
  - The granted port, `last_grant`, and the read/write type are latched for the rest of the transaction.
- ACCESS → CAPTURE edge:
  - Memory samples the address and, for a write, commits `DIn`.
  - `Mem_Write_EN` returns to 1 and the Ack clears.
- CAPTURE → IDLE edge:
  - Read: `Mem_DOut` is registered into the granted port's data output and its Valid is set for one cycle.
  - Write: `Data_Valid` is set for one cycle and `Data_RData` is untouched.
- `Mem_Write_EN` is 0 in at most one cycle per transaction (the ACCESS cycle of a write). It is never 0 in IDLE or CAPTURE.
- A requester may keep Req high after Ack to issue a back-to-back request. That request is re-sampled in the next IDLE.
- Reset values: state IDLE, `last_grant` fetch, `Mem_Address` 0, `Mem_DIn` 0, `Mem_Write_EN` 1, both Acks 0, both Valids 0, `Fetch_Data` 0, `Data_RData` 0.
- Reset mid-transaction:
  - The FSM returns to IDLE and no Valid is produced.
  - `Mem_Write_EN` is 1 from the reset edge onward.
  - A write whose ACCESS cycle already completed before the reset edge remains committed in memory.

## Timing
- The grant edge is E0; the request is present in the cycle before E0.
  - Ack is high in the cycle following E0.
  - The memory samples at E1.
  - Valid is high in the cycle following E2, with data valid in that same cycle.
- Latency from request sampled to Valid is 3 edges.
- Throughput: the earliest next grant is at E3, so one access per 3 cycles. Sustained alternating fetch/data traffic completes one access per 3 cycles.
- Ack and Valid are never high in the same cycle for the same port.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Single fetch: after reset, `Fetch_Req`=1, `Fetch_Addr`=0x00 with memory preloaded 0x9202 → `Fetch_Ack` pulse one cycle after grant edge; `Fetch_Valid` pulse 3 edges after sample with `Fetch_Data`=0x9202; `Mem_Write_EN` stays 1 throughout.
- Write then read: data write 0x0666 to 0x0A → `Mem_Write_EN`=0 for exactly one cycle, `Data_Valid` pulse, `Data_RData` unchanged; then data read 0x0A → `Data_RData`=0x0666 with `Data_Valid`.
- Contention: both ports request continuously after reset (fetch 0x01→0x9304, data read 0x02→0x2621) → grant order data, fetch, data, fetch; each Valid pulse 3 cycles apart; correct data on each port.
- Back-to-back fetches: `Fetch_Req` held high with address stepping 0x00..0x03 after each Ack → data 0x9202, 0x9304, 0x2621, 0x1000, one Valid every 3 cycles.
- Reset mid-read: assert `Reset` in CAPTURE cycle of a fetch → no `Fetch_Valid`, `Fetch_Data`=0, FSM IDLE; next fetch of 0x00 returns 0x9202 normally.
- Idle quiet: no requests for 20 cycles → no Ack/Valid pulses, `Mem_Write_EN`=1, `Mem_Address` holds last value.

Source files
------------

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory between an instruction-fetch
// port and a data load/store port; every transaction takes IDLE -> ACCESS -> CAPTURE.
module memory_arbiter #(
    parameter int Data_WIDTH    = 16,
    parameter int Address_WIDTH = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Fetch_Req,
    input  logic [Address_WIDTH-1:0] Fetch_Addr,
    output logic                     Fetch_Ack,
    output logic [Data_WIDTH-1:0]    Fetch_Data,
    output logic                     Fetch_Valid,
    input  logic                     Data_Req,
    input  logic                     Data_We,
    input  logic [Address_WIDTH-1:0] Data_Addr,
    input  logic [Data_WIDTH-1:0]    Data_WData,
    output logic                     Data_Ack,
    output logic [Data_WIDTH-1:0]    Data_RData,
    output logic                     Data_Valid,
    output logic [Address_WIDTH-1:0] Mem_Address,
    output logic [Data_WIDTH-1:0]    Mem_DIn,
    output logic                     Mem_Write_EN,
    input  logic [Data_WIDTH-1:0]    Mem_DOut
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t r_state;
    logic   r_last_data;   // last grant went to the data port; also the in-flight owner
    logic   r_is_write;
    logic   w_any_req;
    logic   w_grant_data;

    // Grant decision: a lone requester wins, a tie goes to the port not served last
    always_comb begin
        w_any_req    = Fetch_Req | Data_Req;
        w_grant_data = Data_Req & (~Fetch_Req | ~r_last_data);
    end

    // Transaction sequencer with all memory-side and requester-side outputs registered
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_last_data  <= 1'b0;
            r_is_write   <= 1'b0;
            Mem_Address  <= {Address_WIDTH{1'b0}};
            Mem_DIn      <= {Data_WIDTH{1'b0}};
            Mem_Write_EN <= 1'b1;
            Fetch_Ack    <= 1'b0;
            Data_Ack     <= 1'b0;
            Fetch_Valid  <= 1'b0;
            Data_Valid   <= 1'b0;
            Fetch_Data   <= {Data_WIDTH{1'b0}};
            Data_RData   <= {Data_WIDTH{1'b0}};
        end else begin
            Fetch_Ack    <= 1'b0;
            Data_Ack     <= 1'b0;
            Fetch_Valid  <= 1'b0;
            Data_Valid   <= 1'b0;
            Mem_Write_EN <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state     <= S_ACCESS;
                        r_last_data <= w_grant_data;
                        r_is_write  <= w_grant_data & Data_We;
                        if (w_grant_data) begin
                            Mem_Address <= Data_Addr;
                            Data_Ack    <= 1'b1;
                            if (Data_We) begin
                                Mem_DIn      <= Data_WData;
                                Mem_Write_EN <= 1'b0;
                            end else begin
                                Mem_DIn <= Mem_DIn;
                            end
                        end else begin
                            Mem_Address <= Fetch_Addr;
                            Fetch_Ack   <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_state <= S_IDLE;
                    // Writes report completion only; the read-data register keeps its word
                    if (r_is_write) begin
                        Data_Valid <= 1'b1;
                    end else if (r_last_data) begin
                        Data_RData <= Mem_DOut;
                        Data_Valid <= 1'b1;
                    end else begin
                        Fetch_Data  <= Mem_DOut;
                        Fetch_Valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter with a behavioural synchronous-read memory
// and a transaction-level reference model for randomized two-port traffic.
module tb_memory_arbiter;

    logic        Clk;
    logic        Reset;
    logic        Fetch_Req;
    logic [7:0]  Fetch_Addr;
    logic        Fetch_Ack;
    logic [15:0] Fetch_Data;
    logic        Fetch_Valid;
    logic        Data_Req;
    logic        Data_We;
    logic [7:0]  Data_Addr;
    logic [15:0] Data_WData;
    logic        Data_Ack;
    logic [15:0] Data_RData;
    logic        Data_Valid;
    logic [7:0]  Mem_Address;
    logic [15:0] Mem_DIn;
    logic        Mem_Write_EN;
    logic [15:0] Mem_DOut;

    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;
    logic [15:0] bmem [256];

    int n_chk  = 0;
    int n_fail = 0;

    memory_arbiter #(.Data_WIDTH(16), .Address_WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset),
        .Fetch_Req(Fetch_Req), .Fetch_Addr(Fetch_Addr), .Fetch_Ack(Fetch_Ack),
        .Fetch_Data(Fetch_Data), .Fetch_Valid(Fetch_Valid),
        .Data_Req(Data_Req), .Data_We(Data_We), .Data_Addr(Data_Addr),
        .Data_WData(Data_WData), .Data_Ack(Data_Ack), .Data_RData(Data_RData),
        .Data_Valid(Data_Valid), .Mem_Address(Mem_Address), .Mem_DIn(Mem_DIn),
        .Mem_Write_EN(Mem_Write_EN), .Mem_DOut(Mem_DOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous-read memory: old data out, active-low write, bench-side preload port
    always @(posedge Clk) begin
        Mem_DOut <= bmem[Mem_Address];
        if (!Mem_Write_EN) bmem[Mem_Address] = Mem_DIn;
        if (ld_en) bmem[ld_addr] = ld_data;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        n_chk++; if (Fetch_Ack !== 1'b0) begin n_fail++; $display("FAIL rst_fack: got %b want 0", Fetch_Ack); end
        n_chk++; if (Data_Ack !== 1'b0) begin n_fail++; $display("FAIL rst_dack: got %b want 0", Data_Ack); end
        n_chk++; if (Fetch_Valid !== 1'b0 || Data_Valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b%b want 00", Fetch_Valid, Data_Valid); end
        n_chk++; if (Fetch_Data !== 16'h0000) begin n_fail++; $display("FAIL rst_fdata: got %h want 0000", Fetch_Data); end
        n_chk++; if (Data_RData !== 16'h0000) begin n_fail++; $display("FAIL rst_rdata: got %h want 0000", Data_RData); end
        n_chk++; if (Mem_Address !== 8'h00) begin n_fail++; $display("FAIL rst_addr: got %h want 00", Mem_Address); end
        n_chk++; if (Mem_DIn !== 16'h0000) begin n_fail++; $display("FAIL rst_din: got %h want 0000", Mem_DIn); end
        n_chk++; if (Mem_Write_EN !== 1'b1) begin n_fail++; $display("FAIL rst_we: got %b want 1", Mem_Write_EN); end
        Reset = 1'b0;
    endtask

    task automatic test_single_fetch();
        Fetch_Req = 1'b1; Fetch_Addr = 8'h00;
        tick();
        n_chk++; if (Fetch_Ack !== 1'b1 || Data_Ack !== 1'b0) begin n_fail++; $display("FAIL sf_ack: got f%b d%b want f1 d0", Fetch_Ack, Data_Ack); end
        n_chk++; if (Mem_Address !== 8'h00 || Mem_Write_EN !== 1'b1) begin n_fail++; $display("FAIL sf_mem: got %h/%b want 00/1", Mem_Address, Mem_Write_EN); end
        Fetch_Req = 1'b0;
        tick();
        n_chk++; if (Fetch_Ack !== 1'b0 || Fetch_Valid !== 1'b0 || Mem_Write_EN !== 1'b1) begin n_fail++; $display("FAIL sf_e1: got ack%b v%b we%b want 0 0 1", Fetch_Ack, Fetch_Valid, Mem_Write_EN); end
        tick();
        n_chk++; if (Fetch_Valid !== 1'b1 || Fetch_Data !== 16'h9202) begin n_fail++; $display("FAIL sf_valid: got v%b %h want v1 9202", Fetch_Valid, Fetch_Data); end
        n_chk++; if (Data_Valid !== 1'b0 || Mem_Write_EN !== 1'b1) begin n_fail++; $display("FAIL sf_side: got dv%b we%b want 0 1", Data_Valid, Mem_Write_EN); end
        tick();
        n_chk++; if (Fetch_Valid !== 1'b0) begin n_fail++; $display("FAIL sf_pulse: got %b want 0", Fetch_Valid); end
    endtask

    task automatic test_write_read();
        int we_low;
        we_low = 0;
        Data_Req = 1'b1; Data_We = 1'b1; Data_Addr = 8'h0A; Data_WData = 16'h0666;
        tick();
        n_chk++; if (Data_Ack !== 1'b1 || Mem_Address !== 8'h0A || Mem_DIn !== 16'h0666) begin n_fail++; $display("FAIL wr_grant: got ack%b %h %h want 1 0a 0666", Data_Ack, Mem_Address, Mem_DIn); end
        if (Mem_Write_EN === 1'b0) we_low++;
        Data_Req = 1'b0; Data_We = 1'b0;
        tick();
        if (Mem_Write_EN === 1'b0) we_low++;
        n_chk++; if (Data_Ack !== 1'b0) begin n_fail++; $display("FAIL wr_ackclr: got %b want 0", Data_Ack); end
        tick();
        if (Mem_Write_EN === 1'b0) we_low++;
        n_chk++; if (Data_Valid !== 1'b1 || Data_RData !== 16'h0000) begin n_fail++; $display("FAIL wr_valid: got v%b %h want v1 0000", Data_Valid, Data_RData); end
        tick();
        if (Mem_Write_EN === 1'b0) we_low++;
        n_chk++; if (we_low != 1) begin n_fail++; $display("FAIL wr_we_cycles: got %0d want 1", we_low); end
        Data_Req = 1'b1; Data_We = 1'b0; Data_Addr = 8'h0A;
        tick();
        n_chk++; if (Data_Ack !== 1'b1 || Mem_Write_EN !== 1'b1) begin n_fail++; $display("FAIL rd_grant: got ack%b we%b want 1 1", Data_Ack, Mem_Write_EN); end
        Data_Req = 1'b0;
        tick();
        tick();
        n_chk++; if (Data_Valid !== 1'b1 || Data_RData !== 16'h0666) begin n_fail++; $display("FAIL rd_valid: got v%b %h want v1 0666", Data_Valid, Data_RData); end
        tick();
    endtask

    task automatic test_contention();
        logic exp_data_port;
        do_reset();
        Fetch_Req = 1'b1; Fetch_Addr = 8'h01;
        Data_Req = 1'b1; Data_We = 1'b0; Data_Addr = 8'h02;
        for (int k = 0; k < 4; k++) begin
            exp_data_port = (k % 2 == 0);
            tick();
            n_chk++; if (Data_Ack !== exp_data_port || Fetch_Ack !== !exp_data_port) begin n_fail++; $display("FAIL ct_grant%0d: got f%b d%b want d%b", k, Fetch_Ack, Data_Ack, exp_data_port); end
            if (k == 3) begin Fetch_Req = 1'b0; Data_Req = 1'b0; end
            tick();
            n_chk++; if (Fetch_Valid !== 1'b0 || Data_Valid !== 1'b0) begin n_fail++; $display("FAIL ct_early%0d: got f%b d%b want 00", k, Fetch_Valid, Data_Valid); end
            tick();
            if (exp_data_port) begin
                n_chk++; if (Data_Valid !== 1'b1 || Fetch_Valid !== 1'b0 || Data_RData !== 16'h2621) begin n_fail++; $display("FAIL ct_dvalid%0d: got v%b%b %h want 01 2621", k, Fetch_Valid, Data_Valid, Data_RData); end
            end else begin
                n_chk++; if (Fetch_Valid !== 1'b1 || Data_Valid !== 1'b0 || Fetch_Data !== 16'h9304) begin n_fail++; $display("FAIL ct_fvalid%0d: got v%b%b %h want 10 9304", k, Fetch_Valid, Data_Valid, Fetch_Data); end
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_d [4];
        exp_d[0] = 16'h9202; exp_d[1] = 16'h9304; exp_d[2] = 16'h2621; exp_d[3] = 16'h1000;
        Fetch_Req = 1'b1; Fetch_Addr = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++; if (Fetch_Ack !== 1'b1) begin n_fail++; $display("FAIL bb_ack%0d: got %b want 1", i, Fetch_Ack); end
            if (i == 3) Fetch_Req = 1'b0;
            else Fetch_Addr = 8'(i + 1);
            tick();
            tick();
            n_chk++; if (Fetch_Valid !== 1'b1 || Fetch_Data !== exp_d[i]) begin n_fail++; $display("FAIL bb_data%0d: got v%b %h want v1 %h", i, Fetch_Valid, Fetch_Data, exp_d[i]); end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        Fetch_Req = 1'b1; Fetch_Addr = 8'h01;
        tick();
        Fetch_Req = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        n_chk++; if (Fetch_Valid !== 1'b0 || Fetch_Data !== 16'h0000 || Mem_Write_EN !== 1'b1) begin n_fail++; $display("FAIL rm_read: got v%b %h we%b want 0 0000 1", Fetch_Valid, Fetch_Data, Mem_Write_EN); end
        Reset = 1'b0;
        tick();
        n_chk++; if (Fetch_Valid !== 1'b0) begin n_fail++; $display("FAIL rm_novalid: got %b want 0", Fetch_Valid); end
        Fetch_Req = 1'b1; Fetch_Addr = 8'h00;
        tick();
        n_chk++; if (Fetch_Ack !== 1'b1) begin n_fail++; $display("FAIL rm_idle: got %b want 1", Fetch_Ack); end
        Fetch_Req = 1'b0;
        tick();
        tick();
        n_chk++; if (Fetch_Valid !== 1'b1 || Fetch_Data !== 16'h9202) begin n_fail++; $display("FAIL rm_refetch: got v%b %h want v1 9202", Fetch_Valid, Fetch_Data); end
        Data_Req = 1'b1; Data_We = 1'b1; Data_Addr = 8'h0B; Data_WData = 16'h1234;
        tick();
        Data_Req = 1'b0; Data_We = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        n_chk++; if (Data_Valid !== 1'b0 || Mem_Write_EN !== 1'b1) begin n_fail++; $display("FAIL rm_write: got v%b we%b want 0 1", Data_Valid, Mem_Write_EN); end
        Reset = 1'b0;
        tick();
        Data_Req = 1'b1; Data_Addr = 8'h0B;
        tick();
        Data_Req = 1'b0;
        tick();
        tick();
        n_chk++; if (Data_Valid !== 1'b1 || Data_RData !== 16'h1234) begin n_fail++; $display("FAIL rm_commit: got v%b %h want v1 1234", Data_Valid, Data_RData); end
        tick();
    endtask

    task automatic test_idle_quiet();
        int bad;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (Fetch_Ack !== 1'b0 || Data_Ack !== 1'b0 || Fetch_Valid !== 1'b0 || Data_Valid !== 1'b0
                || Mem_Write_EN !== 1'b1 || Mem_Address !== 8'h0B) bad++;
        end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL idle_quiet: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_random();
        logic [15:0] shadow [16];
        logic        f_pend, d_pend, d_we, last_d, gf, gd, we_exp, v_is_data, v_write;
        logic        exp_fv, exp_dv;
        logic [7:0]  f_addr, d_addr;
        logic [15:0] d_wdata, v_val, exp_fd, exp_rd;
        int          next_free, valid_at;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            shadow[i] = 16'($urandom);
            load_word(8'(i), shadow[i]);
        end
        f_pend = 1'b0; d_pend = 1'b0; d_we = 1'b0; last_d = 1'b0;
        f_addr = 8'h00; d_addr = 8'h00; d_wdata = 16'h0000;
        v_is_data = 1'b0; v_write = 1'b0; v_val = 16'h0000;
        exp_fd = 16'h0000; exp_rd = 16'h0000;
        next_free = 0; valid_at = -1;
        for (int n = 0; n < 800; n++) begin
            if (!f_pend && $urandom_range(0, 2) == 0) begin
                f_pend = 1'b1; f_addr = 8'($urandom_range(0, 15));
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_addr = 8'($urandom_range(0, 15)); d_wdata = 16'($urandom);
            end
            Fetch_Req = f_pend; Fetch_Addr = f_addr;
            Data_Req = d_pend; Data_We = d_we; Data_Addr = d_addr; Data_WData = d_wdata;
            tick();
            exp_fv = 1'b0; exp_dv = 1'b0;
            if (n == valid_at) begin
                if (v_is_data) begin
                    exp_dv = 1'b1;
                    if (!v_write) exp_rd = v_val;
                end else begin
                    exp_fv = 1'b1; exp_fd = v_val;
                end
            end
            gf = 1'b0; gd = 1'b0; we_exp = 1'b1;
            if (n >= next_free && (f_pend || d_pend)) begin
                gd = d_pend && (!f_pend || !last_d);
                gf = !gd;
                last_d = gd;
                next_free = n + 3;
                valid_at = n + 2;
                v_is_data = gd;
                if (gd) begin
                    d_pend = 1'b0;
                    v_write = d_we;
                    if (d_we) begin
                        shadow[d_addr[3:0]] = d_wdata;
                        we_exp = 1'b0;
                    end
                    v_val = shadow[d_addr[3:0]];
                    n_chk++; if (Mem_Address !== d_addr || (d_we && Mem_DIn !== d_wdata)) begin n_fail++; $display("FAIL rnd_daddr@%0d: got %h/%h want %h/%h", n, Mem_Address, Mem_DIn, d_addr, d_wdata); end
                end else begin
                    f_pend = 1'b0;
                    v_write = 1'b0;
                    v_val = shadow[f_addr[3:0]];
                    n_chk++; if (Mem_Address !== f_addr) begin n_fail++; $display("FAIL rnd_faddr@%0d: got %h want %h", n, Mem_Address, f_addr); end
                end
            end
            n_chk++; if (Fetch_Ack !== gf || Data_Ack !== gd) begin n_fail++; $display("FAIL rnd_ack@%0d: got f%b d%b want f%b d%b", n, Fetch_Ack, Data_Ack, gf, gd); end
            n_chk++; if (Mem_Write_EN !== we_exp) begin n_fail++; $display("FAIL rnd_we@%0d: got %b want %b", n, Mem_Write_EN, we_exp); end
            n_chk++; if (Fetch_Valid !== exp_fv || Data_Valid !== exp_dv) begin n_fail++; $display("FAIL rnd_valid@%0d: got f%b d%b want f%b d%b", n, Fetch_Valid, Data_Valid, exp_fv, exp_dv); end
            n_chk++; if (Fetch_Data !== exp_fd || Data_RData !== exp_rd) begin n_fail++; $display("FAIL rnd_data@%0d: got %h %h want %h %h", n, Fetch_Data, Data_RData, exp_fd, exp_rd); end
        end
        Fetch_Req = 1'b0; Data_Req = 1'b0;
        tick();
    endtask

    initial begin
        Reset = 1'b1; Fetch_Req = 1'b0; Fetch_Addr = 8'h00;
        Data_Req = 1'b0; Data_We = 1'b0; Data_Addr = 8'h00; Data_WData = 16'h0000;
        ld_en = 1'b0; ld_addr = 8'h00; ld_data = 16'h0000;
        tick();
        load_word(8'h00, 16'h9202);
        load_word(8'h01, 16'h9304);
        load_word(8'h02, 16'h2621);
        load_word(8'h03, 16'h1000);
        load_word(8'h0A, 16'h0000);
        load_word(8'h0B, 16'h0000);
        test_reset();
        test_single_fetch();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        test_idle_quiet();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
